duty_ramp_ctrl: RTL and testbench
=================================

Name: duty_ramp_ctrl

Overview:
Soft-start / slew-limited duty source placed directly upstream of the 8-bit PWM generator. Accepts a target duty from control logic and steps its duty output toward it. Duty changes only on the PWM period-boundary strobe, so a PWM period never sees a mid-period duty change. Provides ramp-up on enable, ramp-down to 0 on disable, and status flags for the sequencer.

Parameters:
DW, 8, duty width; matches the PWM duty input.
STEP, 4, duty increment/decrement applied per step (1..2^DW-1).
CYCLES_PER_STEP, 2, PWM periods (cycle strobes) per step (>=1).
DUTY_MAX, 200, target clamp value; used only with DUTY_RAMP_LIMIT_EN.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
enable  in  1  level; 1 = run/ramp to target, 0 = ramp down to 0.
target  in  DW  requested duty.
target_valid  in  1  one-clock strobe; latches target.
cycle  in  1  one-clock PWM period-boundary strobe from the PWM block.
duty  out  DW  registered duty to the PWM block.
busy  out  1  registered; 1 in RAMP or SHUTDOWN.
at_target  out  1  registered; 1 in HOLD.

Behaviour:
- Reset (rst=1 at clk edge): duty=0, busy=0, at_target=0, target_reg=0, div_cnt=0, state=OFF. Overrides all other inputs, including mid-ramp.
- target_reg <= target on any clock with target_valid=1, in every state. A step taken on the same clock uses the old target_reg.
- Step engine runs only in RAMP/SHUTDOWN, on clocks with cycle=1:
  - div_cnt==CYCLES_PER_STEP-1: div_cnt<=0 and apply one step.
  - Otherwise: div_cnt<=div_cnt+1.
- Step toward goal G (G=target_reg in RAMP, G=0 in SHUTDOWN):
  - duty<G: duty <= (G-duty<=STEP) ? G : duty+STEP.
  - duty>G: duty <= (duty-G<=STEP) ? G : duty-STEP.
  - Compute in DW+1 bits; no wrap, no overshoot.
- div_cnt clears to 0 on every entry into RAMP or SHUTDOWN.
- No cycle strobe: duty is frozen in every state.
- States/transitions (evaluated each clock, priority top-down):
  - OFF: duty held 0. enable=1 and target_reg!=0 -> RAMP. enable=1 and target_reg==0 -> HOLD.
  - RAMP: enable=0 -> SHUTDOWN. Else, when the step result equals target_reg -> HOLD on the same edge as the duty update. Else stay.
  - HOLD: enable=0 -> SHUTDOWN. Else target_reg!=duty -> RAMP. Else stay.
  - SHUTDOWN: enable=1 -> RAMP. Else, when the step result equals 0 -> OFF. Else stay.
- busy/at_target are registered from the next state, so they are valid on the same clock as the duty update that caused the transition.
- enable falling together with target_valid: target is latched, state -> SHUTDOWN.
- Target changed while ramping: direction follows the new target_reg from the next strobe. May reverse mid-ramp.
- Latency: target_valid to first duty change = CYCLES_PER_STEP cycle strobes (when entering from HOLD/OFF).

Optional Feature:
DUTY_RAMP_LIMIT_EN
- Defined: target is clamped at latch time, target_reg <= min(target, DUTY_MAX). Duty never exceeds DUTY_MAX.
- Undefined: target latched unmodified; full 0..2^DW-1 range. DUTY_MAX is unused.

Test Plan:
1. Defaults, reset, enable=1, target=16 strobed, cycle pulse every 10 clocks -> duty 0 after pulse1, 4 after pulse2, 8/12/16 after pulses 4/6/8. After pulse8: at_target=1, busy=0.
2. From OFF, target=10 -> duty 4, 8, 10 after pulses 2, 4, 6. Never 12. at_target=1 after pulse6.
3. HOLD at 16, target_valid with target=6 -> busy=1 next clock. duty 12, 8, 6 after pulses 2, 4, 6, then HOLD.
4. Ramping at duty=8 toward 40, enable->0 -> SHUTDOWN. duty 4, then 0 two pulses later. State OFF, busy=0, at_target=0. Re-enable -> ramps back toward 40.
5. HOLD at 16, target=100 strobed, cycle held 0 for 500 clocks -> duty stays 16, busy=1. Then rst=1 for one clock mid-ramp (duty=24) -> next clock duty=0, busy=0, at_target=0.
6. With DUTY_RAMP_LIMIT_EN, DUTY_MAX=200, target=255 -> duty settles at 200, at_target=1. Without the macro -> settles at 255 (last step 252->255).

Source files
------------

// File: rtl/duty_ramp_ctrl.sv
// duty_ramp_ctrl: slew-limited duty source feeding an 8-bit PWM generator.
// Steps duty toward a latched target, only on PWM period-boundary strobes,
// so a PWM period never sees a mid-period duty change. Ramps up on enable
// and ramps down to 0 on disable.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   enable        level: 1 = ramp to target, 0 = ramp down to 0
//   target        requested duty
//   target_valid  one-clock strobe latching target
//   cycle         one-clock PWM period-boundary strobe
//   duty          registered duty to the PWM block
//   busy          registered, 1 while ramping or shutting down
//   at_target     registered, 1 while holding at target
//
// Build option: define DUTY_RAMP_LIMIT_EN to clamp the latched target to
// DUTY_MAX; otherwise the full 0..2^DW-1 range is used.
module duty_ramp_ctrl #(
    parameter int unsigned DW              = 8,
    parameter int unsigned STEP            = 4,
    parameter int unsigned CYCLES_PER_STEP = 2,
    parameter int unsigned DUTY_MAX        = 200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [DW-1:0] target,
    input  logic          target_valid,
    input  logic          cycle,
    output logic [DW-1:0] duty,
    output logic          busy,
    output logic          at_target
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RAMP,
        ST_HOLD,
        ST_SHUTDOWN
    } state_t;

    localparam int unsigned CW       = (CYCLES_PER_STEP > 1) ? $clog2(CYCLES_PER_STEP) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CYCLES_PER_STEP - 1);
    localparam logic [DW:0]   STEP_X   = (DW + 1)'(STEP);

`ifdef DUTY_RAMP_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    // With the limit disabled the cap is all-ones, so the clamp never bites.
    localparam logic [DW-1:0] TGT_CAP = LIMIT_EN ? DW'(DUTY_MAX) : {DW{1'b1}};

    state_t        state_q, state_d;
    logic [DW-1:0] duty_q, duty_d;
    logic [DW-1:0] tgt_q, tgt_d;
    logic [CW-1:0] div_q, div_d;
    logic          busy_q, busy_d;
    logic          at_q, at_d;

    logic [DW-1:0] goal;
    logic [DW:0]   goal_x, duty_x;
    logic [DW-1:0] step_res;
    logic          stepping;
    logic          step_fire;

    // One step from duty toward the goal, saturating at the goal.
    always_comb begin
        goal     = (state_q == ST_SHUTDOWN) ? '0 : tgt_q;
        goal_x   = {1'b0, goal};
        duty_x   = {1'b0, duty_q};
        step_res = duty_q;
        if (duty_x < goal_x) begin
            step_res = ((goal_x - duty_x) <= STEP_X) ? goal : DW'(duty_x + STEP_X);
        end else if (duty_x > goal_x) begin
            step_res = ((duty_x - goal_x) <= STEP_X) ? goal : DW'(duty_x - STEP_X);
        end
    end

    assign stepping  = (state_q == ST_RAMP) || (state_q == ST_SHUTDOWN);
    assign step_fire = stepping && cycle && (div_q == DIV_LAST);

    // Next-state, step engine and target latch.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        div_d   = div_q;
        tgt_d   = tgt_q;

        if (target_valid) begin
            tgt_d = (target > TGT_CAP) ? TGT_CAP : target;
        end

        if (stepping && cycle) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                duty_d = step_res;
            end else begin
                div_d = div_q + CW'(1);
            end
        end

        case (state_q)
            ST_OFF: begin
                duty_d = '0;
                if (enable) begin
                    if (tgt_q != '0) begin
                        state_d = ST_RAMP;
                        div_d   = '0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_RAMP: begin
                if (!enable) begin
                    state_d = ST_SHUTDOWN;
                    div_d   = '0;
                end else if (step_fire && (step_res == tgt_q)) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!enable) begin
                    state_d = ST_SHUTDOWN;
                    div_d   = '0;
                end else if (tgt_q != duty_q) begin
                    state_d = ST_RAMP;
                    div_d   = '0;
                end
            end
            ST_SHUTDOWN: begin
                if (enable) begin
                    state_d = ST_RAMP;
                    div_d   = '0;
                end else if (step_fire && (step_res == '0)) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        // Flags follow the next state so they line up with the duty update.
        busy_d = (state_d == ST_RAMP) || (state_d == ST_SHUTDOWN);
        at_d   = (state_d == ST_HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            duty_q  <= '0;
            tgt_q   <= '0;
            div_q   <= '0;
            busy_q  <= 1'b0;
            at_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            div_q   <= div_d;
            busy_q  <= busy_d;
            at_q    <= at_d;
        end
    end

    assign duty      = duty_q;
    assign busy      = busy_q;
    assign at_target = at_q;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Scoreboard bench for duty_ramp_ctrl with default parameters
// (DW=8, STEP=4, CYCLES_PER_STEP=2, DUTY_MAX=200).
module tb_duty_ramp_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] target;
    logic       target_valid;
    logic       cycle;
    logic [7:0] duty;
    logic       busy;
    logic       at_target;

    logic       chk_req;

    typedef struct {
        logic [7:0] d;
        logic       b;
        logic       a;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

`ifdef DUTY_RAMP_LIMIT_EN
    localparam int N_LAST = 100;
    localparam int PEN    = 196;
    localparam int FIN    = 200;
`else
    localparam int N_LAST = 128;
    localparam int PEN    = 252;
    localparam int FIN    = 255;
`endif

    duty_ramp_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .target       (target),
        .target_valid (target_valid),
        .cycle        (cycle),
        .duty         (duty),
        .busy         (busy),
        .at_target    (at_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: after any edge flagged for checking, pop and compare at negedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (chk_req) begin
                @(negedge clk);
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_empty: output presented with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    if (duty !== e.d || busy !== e.b || at_target !== e.a) begin
                        fails++;
                        $display("FAIL %s: got duty=%0d busy=%0b at_target=%0b, want duty=%0d busy=%0b at_target=%0b",
                                 e.nm, duty, busy, at_target, e.d, e.b, e.a);
                    end
                end
            end
        end
    end

    // One clock of stimulus; optionally queues the expected post-edge outputs.
    task automatic tick(input bit cyc, input bit tv, input logic [7:0] tg,
                        input bit chk, input logic [7:0] d, input bit b,
                        input bit a, input string nm);
        exp_t e;
        cycle        = cyc;
        target_valid = tv;
        if (tv) target = tg;
        chk_req      = chk;
        if (chk) begin
            e.d = d; e.b = b; e.a = a; e.nm = nm;
            exp_q.push_back(e);
        end
        @(negedge clk);
        cycle        = 1'b0;
        target_valid = 1'b0;
        chk_req      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, "");
    endtask

    task automatic pulse(input bit chk, input logic [7:0] d, input bit b,
                         input bit a, input string nm);
        idle(9);
        tick(1'b1, 1'b0, 8'd0, chk, d, b, a, nm);
    endtask

    task automatic pulse_nc();
        pulse(1'b0, 8'd0, 1'b0, 1'b0, "");
    endtask

    task automatic strobe_target(input logic [7:0] tg);
        tick(1'b0, 1'b1, tg, 1'b0, 8'd0, 1'b0, 1'b0, "");
    endtask

    initial begin
        int guard;
        rst = 1'b1; enable = 1'b0; target = 8'd0; target_valid = 1'b0;
        cycle = 1'b0; chk_req = 1'b0;
        @(negedge clk);
        tick(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, "reset_state");
        rst = 1'b0;

        // Ramp 0 -> 16 from OFF
        enable = 1'b1;
        strobe_target(8'd16);
        idle(1);
        pulse(1'b1, 8'd0,  1'b1, 1'b0, "t1_p1");
        pulse(1'b1, 8'd4,  1'b1, 1'b0, "t1_p2");
        pulse(1'b1, 8'd4,  1'b1, 1'b0, "t1_p3");
        pulse(1'b1, 8'd8,  1'b1, 1'b0, "t1_p4");
        pulse(1'b1, 8'd8,  1'b1, 1'b0, "t1_p5");
        pulse(1'b1, 8'd12, 1'b1, 1'b0, "t1_p6");
        pulse(1'b1, 8'd12, 1'b1, 1'b0, "t1_p7");
        pulse(1'b1, 8'd16, 1'b0, 1'b1, "t1_p8_hold");

        // Ramp down 16 -> 6 from HOLD, last step partial
        strobe_target(8'd6);
        tick(1'b0, 1'b0, 8'd0, 1'b1, 8'd16, 1'b1, 1'b0, "t3_busy_after_strobe");
        pulse(1'b1, 8'd16, 1'b1, 1'b0, "t3_p1");
        pulse(1'b1, 8'd12, 1'b1, 1'b0, "t3_p2");
        pulse_nc();
        pulse(1'b1, 8'd8,  1'b1, 1'b0, "t3_p4");
        pulse_nc();
        pulse(1'b1, 8'd6,  1'b0, 1'b1, "t3_p6_hold");

        // Shut down 6 -> 0, then ramp 0 -> 10 without overshoot
        enable = 1'b0;
        idle(1);
        pulse_nc();
        pulse(1'b1, 8'd2, 1'b1, 1'b0, "t2_sd_p2");
        pulse_nc();
        pulse(1'b1, 8'd0, 1'b0, 1'b0, "t2_sd_off");
        strobe_target(8'd10);
        enable = 1'b1;
        tick(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0, "t2_off_to_ramp");
        pulse(1'b1, 8'd0,  1'b1, 1'b0, "t2_p1");
        pulse(1'b1, 8'd4,  1'b1, 1'b0, "t2_p2");
        pulse_nc();
        pulse(1'b1, 8'd8,  1'b1, 1'b0, "t2_p4");
        pulse(1'b1, 8'd8,  1'b1, 1'b0, "t2_p5");
        pulse(1'b1, 8'd10, 1'b0, 1'b1, "t2_p6_hold");

        // Back to OFF, ramp toward 40, disable mid-ramp, re-enable
        enable = 1'b0;
        idle(1);
        pulse_nc();
        pulse(1'b1, 8'd6, 1'b1, 1'b0, "t4_sd_p2");
        pulse_nc(); pulse_nc(); pulse_nc();
        pulse(1'b1, 8'd0, 1'b0, 1'b0, "t4_sd_off");
        strobe_target(8'd40);
        enable = 1'b1;
        idle(1);
        pulse_nc(); pulse_nc(); pulse_nc();
        pulse(1'b1, 8'd8, 1'b1, 1'b0, "t4_at8");
        enable = 1'b0;
        tick(1'b0, 1'b0, 8'd0, 1'b1, 8'd8, 1'b1, 1'b0, "t4_shutdown_entry");
        pulse(1'b1, 8'd8, 1'b1, 1'b0, "t4_sd_p1");
        pulse(1'b1, 8'd4, 1'b1, 1'b0, "t4_sd_p2b");
        pulse_nc();
        pulse(1'b1, 8'd0, 1'b0, 1'b0, "t4_off");
        enable = 1'b1;
        tick(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0, "t4_reenable");
        pulse(1'b1, 8'd0, 1'b1, 1'b0, "t4_re_p1");
        pulse(1'b1, 8'd4, 1'b1, 1'b0, "t4_re_p2");
        strobe_target(8'd16);
        pulse_nc();
        pulse(1'b1, 8'd8, 1'b1, 1'b0, "t4_re_p4");
        pulse_nc(); pulse_nc(); pulse_nc();
        pulse(1'b1, 8'd16, 1'b0, 1'b1, "t4_retarget_hold");

        // No strobes: duty frozen; then reset mid-ramp
        strobe_target(8'd100);
        tick(1'b0, 1'b0, 8'd0, 1'b1, 8'd16, 1'b1, 1'b0, "t5_hold_to_ramp");
        idle(500);
        tick(1'b0, 1'b0, 8'd0, 1'b1, 8'd16, 1'b1, 1'b0, "t5_frozen");
        pulse_nc();
        pulse(1'b1, 8'd20, 1'b1, 1'b0, "t5_p2");
        pulse_nc();
        pulse(1'b1, 8'd24, 1'b1, 1'b0, "t5_p4");
        rst = 1'b1;
        tick(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, "t5_reset_mid_ramp");
        rst = 1'b0;
        tick(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1, "t5_off_zero_target_hold");

        // Full-scale target: clamp or last partial step
        strobe_target(8'd255);
        for (int i = 1; i <= N_LAST; i++) begin
            if (i == N_LAST - 2)
                pulse(1'b1, 8'(PEN), 1'b1, 1'b0, "t6_penultimate");
            else if (i == N_LAST)
                pulse(1'b1, 8'(FIN), 1'b0, 1'b1, "t6_final");
            else
                pulse_nc();
        end
        pulse_nc(); pulse_nc(); pulse_nc();
        pulse(1'b1, 8'(FIN), 1'b0, 1'b1, "t6_settled");

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
